// File: rtl/psum_acc_tree_if.sv
// Beat-in / group-sum-out handshake bundle for psum_acc_tree.
// Widths come from the same three parameters the block uses.
interface psum_acc_tree_if #(
  parameter int N_IN  = 9,
  parameter int IN_W  = 25,
  parameter int ACC_W = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [N_IN*IN_W-1:0]    in_data;
  logic                    in_first;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_sum;
  logic                    ovf;

  modport master (
    output in_valid, in_data, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_sum, ovf
  );

  modport slave (
    input  in_valid, in_data, in_first, in_last, out_ready,
    output in_ready, out_valid, out_sum, ovf
  );
endinterface

// File: rtl/psum_acc_tree.sv
// Signed N_IN-lane adder tree feeding a group accumulator; PSUM_SAT_EN selects saturating accumulation with sticky ovf.
// Latency $clog2(N_IN)+1 cycles from in_last to out_valid; out_valid && !out_ready freezes every stage and drops in_ready.
module psum_acc_tree #(
  parameter int N_IN  = 9,
  parameter int IN_W  = 25,
  parameter int ACC_W = 32
) (
  input logic            clk,
  input logic            rst_n,
  psum_acc_tree_if.slave bus
);

  localparam int L  = $clog2(N_IN);
  localparam int TW = IN_W + L;

  // Operand count entering tree stage k.
  function automatic int cnt_at(input int k);
    int c;
    c = N_IN;
    for (int i = 0; i < k; i++) c = (c + 1) / 2;
    return c;
  endfunction

  logic stall;
  logic in_xfer;
  logic out_valid_q;
  logic ovf_q;
  logic signed [ACC_W-1:0] out_sum_q;

  assign stall        = out_valid_q && !bus.out_ready;
  assign in_xfer      = bus.in_valid && !stall;
  assign bus.in_ready = !stall;

  for (genvar k = 0; k < L; k++) begin : g_stg
    localparam int NI = cnt_at(k);
    localparam int NO = (NI + 1) / 2;
    localparam int WI = IN_W + k;

    logic signed [WI-1:0] opnd  [NI];
    logic signed [WI:0]   sum_d [NO];
    logic signed [WI:0]   sum_q [NO];
    logic                 src_vld;
    logic                 src_first;
    logic                 src_last;
    logic                 vld_q;
    logic                 first_q;
    logic                 last_q;

    if (k == 0) begin : g_src
      for (genvar i = 0; i < NI; i++) begin : g_ln
        assign opnd[i] = bus.in_data[i*IN_W +: IN_W];
      end
      assign src_vld   = in_xfer;
      assign src_first = bus.in_first;
      assign src_last  = bus.in_last;
    end else begin : g_src
      for (genvar i = 0; i < NI; i++) begin : g_ln
        assign opnd[i] = g_stg[k-1].sum_q[i];
      end
      assign src_vld   = g_stg[k-1].vld_q;
      assign src_first = g_stg[k-1].first_q;
      assign src_last  = g_stg[k-1].last_q;
    end

    // Each stage grows by one bit, so pairwise sums never overflow.
    for (genvar o = 0; o < NO; o++) begin : g_add
      if (2*o + 1 < NI) begin : g_pair
        assign sum_d[o] = {opnd[2*o][WI-1], opnd[2*o]} + {opnd[2*o+1][WI-1], opnd[2*o+1]};
      end else begin : g_pass
        assign sum_d[o] = {opnd[2*o][WI-1], opnd[2*o]};
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q   <= 1'b0;
        first_q <= 1'b0;
        last_q  <= 1'b0;
      end else if (!stall) begin
        vld_q   <= src_vld;
        first_q <= src_first;
        last_q  <= src_last;
      end
    end

    always_ff @(posedge clk) begin
      if (!stall) sum_q <= sum_d;
    end
  end

  logic signed [TW-1:0]    tree_res;
  logic                    tree_vld;
  logic                    tree_first;
  logic                    tree_last;
  logic signed [ACC_W-1:0] res_ext;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_nxt;

  assign tree_res   = g_stg[L-1].sum_q[0];
  assign tree_vld   = g_stg[L-1].vld_q;
  assign tree_first = g_stg[L-1].first_q;
  assign tree_last  = g_stg[L-1].last_q;
  assign res_ext    = ACC_W'(tree_res);
  assign base       = tree_first ? '0 : acc_q;

`ifdef PSUM_SAT_EN
  logic signed [ACC_W:0] wide;
  logic                  sat_hit;

  assign wide    = {base[ACC_W-1], base} + {res_ext[ACC_W-1], res_ext};
  assign sat_hit = wide[ACC_W] ^ wide[ACC_W-1];

  always_comb begin
    acc_nxt = wide[ACC_W-1:0];
    if (sat_hit) acc_nxt = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             ovf_q <= 1'b0;
    else if (!stall && tree_vld && sat_hit) ovf_q <= 1'b1;
  end
`else
  assign acc_nxt = base + res_ext;
  assign ovf_q   = 1'b0;
`endif

  // A closing beat publishes the sum and clears acc so the next group starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= tree_vld && tree_last;
      if (tree_vld) begin
        if (tree_last) begin
          out_sum_q <= acc_nxt;
          acc_q     <= '0;
        end else begin
          acc_q     <= acc_nxt;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_psum_acc_tree.sv
// Scoreboard bench for psum_acc_tree: main 9-lane instance plus a narrow-accumulator instance for saturation/wrap.
module tb_psum_acc_tree;

  localparam int N   = 9;
  localparam int IW  = 25;
  localparam int AW  = 32;
  localparam int N2  = 4;
  localparam int AW2 = 27;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic signed [AW-1:0] sb [$];
  logic signed [AW-1:0] macc = '0;

  always #5 clk = ~clk;

  psum_acc_tree_if #(.N_IN(N),  .IN_W(IW), .ACC_W(AW))  bus ();
  psum_acc_tree_if #(.N_IN(N2), .IN_W(IW), .ACC_W(AW2)) bus2 ();

  psum_acc_tree #(.N_IN(N),  .IN_W(IW), .ACC_W(AW))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  psum_acc_tree #(.N_IN(N2), .IN_W(IW), .ACC_W(AW2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  function automatic logic [N*IW-1:0] mk_data(input int a, input int b);
    logic [N*IW-1:0] d;
    logic [IW-1:0]   lane;
    d = '0;
    for (int i = 0; i < N; i++) begin
      lane = IW'(a + b * i);
      d[i*IW +: IW] = lane;
    end
    return d;
  endfunction

  function automatic logic signed [AW-1:0] lane_sum(input logic [N*IW-1:0] d);
    logic signed [AW-1:0] s;
    logic signed [IW-1:0] lane;
    s = '0;
    for (int i = 0; i < N; i++) begin
      lane = d[i*IW +: IW];
      s = s + AW'(lane);
    end
    return s;
  endfunction

  task automatic model_accept(input logic f, input logic l, input logic [N*IW-1:0] d);
    macc = f ? lane_sum(d) : macc + lane_sum(d);
    if (l) begin
      sb.push_back(macc);
      macc = '0;
    end
  endtask

  // One clock of stimulus on the main instance; reports which transfers the coming edge will perform.
  task automatic drive_cycle(input logic v, input logic f, input logic l, input logic [N*IW-1:0] d,
                             input logic ordy, output logic ox, output logic signed [AW-1:0] os,
                             output logic ix);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_first  = f;
    bus.in_last   = l;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    ox = bus.out_valid && bus.out_ready;
    os = bus.out_sum;
    ix = bus.in_valid && bus.in_ready;
    if (ix) model_accept(f, l, d);
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0;  bus.in_first = 1'b0;  bus.in_last = 1'b0;
    bus.in_data  = '0;    bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_first = 1'b0; bus2.in_last = 1'b0;
    bus2.in_data  = '0;   bus2.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b, required 0", bus.out_valid); end
    checks++; if (bus.out_sum !== '0) begin errors++; $display("FAIL reset_out_sum: got %0d, required 0", bus.out_sum); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b, required 0", bus.ovf); end
    checks++; if (bus2.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf_narrow: got %0b, required 0", bus2.ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b, required 1", bus.in_ready); end
  endtask

  task automatic test_single;
    logic ox, ix, found;
    logic signed [AW-1:0] os, exp;
    int lat;
    found = 1'b0;
    lat = 0;
    drive_cycle(1'b1, 1'b1, 1'b1, mk_data(1, 0), 1'b1, ox, os, ix);
    checks++; if (ix !== 1'b1) begin errors++; $display("FAIL single_accept: got %0b, required 1", ix); end
    for (int c = 1; c <= 20 && !found; c++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, ox, os, ix);
      if (ox) begin
        found = 1'b1;
        lat = c;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL single_sb: got output %0d, required none pending", os); end
        else begin
          exp = sb.pop_front();
          if (os !== exp) begin errors++; $display("FAIL single_sum: got %0d, required %0d", os, exp); end
        end
        checks++; if (os !== 32'sd9) begin errors++; $display("FAIL single_nine: got %0d, required 9", os); end
      end
    end
    checks++; if (!found || lat != 5) begin errors++; $display("FAIL single_latency: got %0d (found %0b), required 5", lat, found); end
  endtask

  task automatic test_group;
    int   lv  [4] = '{-1, 2, 3, 5};
    logic fv  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic lst [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic ox, ix;
    logic signed [AW-1:0] os, exp;
    int k, nsent;
    k = 0;
    nsent = 0;
    for (int c = 0; c < 60; c++) begin
      if (nsent >= 4 && sb.size() == 0) break;
      if (nsent < 4) drive_cycle(1'b1, fv[nsent], lst[nsent], mk_data(lv[nsent], 0), 1'b1, ox, os, ix);
      else           drive_cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, ox, os, ix);
      if (ix) nsent++;
      if (ox) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL group_sb: got output %0d, required none pending", os); end
        else begin
          exp = sb.pop_front();
          if (os !== exp) begin errors++; $display("FAIL group_sum: got %0d, required %0d", os, exp); end
        end
        checks++;
        if (k == 0 && os !== 32'sd36) begin errors++; $display("FAIL group_three_beat: got %0d, required 36", os); end
        if (k == 1 && os !== 32'sd45) begin errors++; $display("FAIL group_orphan_mid: got %0d, required 45", os); end
        k++;
      end
    end
    checks++; if (k != 2) begin errors++; $display("FAIL group_count: got %0d outputs, required 2", k); end
  endtask

  task automatic test_back_to_back;
    logic ox, ix, started;
    logic signed [AW-1:0] os, exp;
    int nsent, nrecv, bubbles;
    nsent = 0; nrecv = 0; bubbles = 0; started = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (c >= 20 && nrecv >= 20) break;
      drive_cycle(c < 20, 1'b1, 1'b1, mk_data(c * 3 - 7, (c % 5) - 2), 1'b1, ox, os, ix);
      if (ix) nsent++;
      if (ox) begin
        started = 1'b1;
        nrecv++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL b2b_sb: got output %0d, required none pending", os); end
        else begin
          exp = sb.pop_front();
          if (os !== exp) begin errors++; $display("FAIL b2b_sum: got %0d, required %0d", os, exp); end
        end
      end else if (started && nrecv < 20) begin
        bubbles++;
      end
    end
    checks++; if (nsent != 20) begin errors++; $display("FAIL b2b_accepted: got %0d, required 20", nsent); end
    checks++; if (nrecv != 20) begin errors++; $display("FAIL b2b_outputs: got %0d, required 20", nrecv); end
    checks++; if (bubbles != 0) begin errors++; $display("FAIL b2b_bubbles: got %0d, required 0", bubbles); end
  endtask

  task automatic test_stall;
    logic ox, ix;
    logic signed [AW-1:0] os, exp, held;
    int nsent, nrecv;
    nsent = 0; nrecv = 0; held = '0;
    for (int c = 0; c < 200; c++) begin
      if (c >= 12 && nsent >= 30 && sb.size() == 0) break;
      drive_cycle(nsent < 30, 1'b1, 1'b1, mk_data(100 + nsent, 1), !(c >= 8 && c < 12), ox, os, ix);
      if (ix) nsent++;
      if (c >= 8 && c < 12) begin
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %0b, required 0 (cycle %0d)", bus.in_ready, c); end
        checks++;
        if (c == 8) begin
          held = os;
          if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid: got %0b, required 1", bus.out_valid); end
        end else if (os !== held) begin
          errors++; $display("FAIL stall_hold: got %0d, required %0d (cycle %0d)", os, held, c);
        end
      end
      if (ox) begin
        nrecv++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL stall_sb: got output %0d, required none pending", os); end
        else begin
          exp = sb.pop_front();
          if (os !== exp) begin errors++; $display("FAIL stall_sum: got %0d, required %0d", os, exp); end
        end
      end
    end
    checks++; if (nrecv != 30) begin errors++; $display("FAIL stall_count: got %0d, required 30", nrecv); end
  endtask

  task automatic test_random;
    logic ox, ix, v, f, l, ordy, open;
    logic signed [AW-1:0] os, exp;
    open = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c >= 400 && !open && sb.size() == 0) break;
      if (c < 400) begin
        v = ($urandom_range(0, 3) != 0);
        f = !open ? 1'b1 : ($urandom_range(0, 7) == 0);
        l = ($urandom_range(0, 2) == 0);
      end else begin
        v = open;
        f = 1'b0;
        l = 1'b1;
      end
      ordy = ($urandom_range(0, 3) != 0);
      drive_cycle(v, f, l, mk_data(int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 20)) - 10),
                  ordy, ox, os, ix);
      if (ix) open = !l;
      if (ox) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL random_sb: got output %0d, required none pending", os); end
        else begin
          exp = sb.pop_front();
          if (os !== exp) begin errors++; $display("FAIL random_sum: got %0d, required %0d", os, exp); end
        end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL random_drain: got %0d pending, required 0", sb.size()); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL random_ovf: got %0b, required 0", bus.ovf); end
  endtask

  task automatic test_midreset;
    logic ox, ix;
    logic signed [AW-1:0] os, exp;
    int nrecv;
    nrecv = 0;
    drive_cycle(1'b1, 1'b1, 1'b1, mk_data(4, 0), 1'b0, ox, os, ix);
    drive_cycle(1'b1, 1'b1, 1'b0, mk_data(7, 0), 1'b0, ox, os, ix);
    drive_cycle(1'b1, 1'b0, 1'b0, mk_data(7, 0), 1'b0, ox, os, ix);
    repeat (4) drive_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, ox, os, ix);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midreset_pre_valid: got %0b, required 1", bus.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %0b, required 0", bus.out_valid); end
    checks++; if (bus.out_sum !== '0) begin errors++; $display("FAIL midreset_out_sum: got %0d, required 0", bus.out_sum); end
    sb.delete();
    macc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      drive_cycle(c == 0, 1'b1, 1'b1, mk_data(3, 0), 1'b1, ox, os, ix);
      if (ox) begin
        nrecv++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL midreset_sb: got output %0d, required none pending", os); end
        else begin
          exp = sb.pop_front();
          if (os !== exp) begin errors++; $display("FAIL midreset_sum: got %0d, required %0d", os, exp); end
        end
        checks++; if (os !== 32'sd27) begin errors++; $display("FAIL midreset_own_sum: got %0d, required 27", os); end
      end
    end
    checks++; if (nrecv != 1) begin errors++; $display("FAIL midreset_count: got %0d outputs, required 1", nrecv); end
  endtask

  task automatic test_sat;
    longint mx, mn, s, acc, modv;
    logic   exp_ovf, found;
    logic signed [AW2-1:0] exp_sum;
    logic [N2*IW-1:0]      d;
    logic [IW-1:0]         lmax;
    lmax = {1'b0, {(IW-1){1'b1}}};
    for (int i = 0; i < N2; i++) d[i*IW +: IW] = lmax;
    mx   = (longint'(1) <<< (AW2 - 1)) - 1;
    mn   = -mx - 1;
    modv = longint'(1) <<< AW2;
    s    = longint'(N2) * ((longint'(1) <<< (IW - 1)) - 1);
    acc  = 0;
    exp_ovf = 1'b0;
    for (int b = 0; b < 4; b++) begin
      acc = (b == 0) ? s : acc + s;
`ifdef PSUM_SAT_EN
      if (acc > mx) begin acc = mx; exp_ovf = 1'b1; end
      if (acc < mn) begin acc = mn; exp_ovf = 1'b1; end
`else
      acc = acc % modv;
      if (acc > mx) acc = acc - modv;
      if (acc < mn) acc = acc + modv;
`endif
    end
    exp_sum = AW2'(acc);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus2.in_valid  = 1'b1;
      bus2.in_first  = (b == 0);
      bus2.in_last   = (b == 3);
      bus2.in_data   = d;
      bus2.out_ready = 1'b1;
    end
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      bus2.in_valid = 1'b0;
      #1;
      if (bus2.out_valid) begin
        found = 1'b1;
        checks++; if (bus2.out_sum !== exp_sum) begin errors++; $display("FAIL sat_sum: got %0d, required %0d", bus2.out_sum, exp_sum); end
        checks++; if (bus2.ovf !== exp_ovf) begin errors++; $display("FAIL sat_ovf: got %0b, required %0b", bus2.ovf, exp_ovf); end
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL sat_timeout: got no out_valid within 20 cycles, required one"); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus2.ovf !== exp_ovf) begin errors++; $display("FAIL sat_ovf_sticky: got %0b, required %0b", bus2.ovf, exp_ovf); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_group();
    test_back_to_back();
    test_stall();
    test_random();
    test_midreset();
    test_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation time limit, required completion");
    $fatal(1);
  end

endmodule
